// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg
// Shared definitions for the PWM audio DAC slice: default sample width and
// FIFO depth, plus the bit positions used when the CPU-side MMIO status
// word is assembled from the underrun pulse and the FIFO level.
package pwm_dac_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_DEPTH = 4;

    // MMIO status word layout: bit 0 = underrun, level starts at bit 1
    localparam int STATUS_UNDERRUN_BIT = 0;
    localparam int STATUS_LEVEL_LSB    = 1;

endpackage

// File: rtl/pwm_dac_if.sv
// pwm_dac_if
// Valid/ready sample stream carrying unsigned WIDTH-bit duty codes.
//   sample_data  : duty code (source -> DAC)
//   sample_valid : sample_data is valid (source -> DAC)
//   sample_ready : DAC can accept a sample this cycle (DAC -> source)
// modport master is the sample source, modport slave is the DAC.
interface pwm_dac_if
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/pwm_dac_sample_fifo.sv
// sample_fifo
// Synchronous first-word-fall-through FIFO holding pending duty codes.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din when push and not full
//   pop        : discard the head entry when pop and not empty
//   dout       : head entry, valid whenever empty is low
//   full, empty, level : occupancy, all derived from registered pointers
module sample_fifo
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra MSB so that equal low bits can mean either
    // empty (MSBs equal) or full (MSBs differ).
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pwm_dac.sv
// pwm_dac
// Consumer end of the audio sample path. Samples arriving on the valid/ready
// stream are queued in a small FIFO; one sample per 2^WIDTH-clock period is
// loaded as the duty code and rendered as a 1-bit PWM waveform.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run the PWM; when low the output idles, FIFO still fills
//   smp          : sample stream (slave side), ready = FIFO not full
//   pwm_out      : registered PWM output
//   period_start : high during the first cycle of each period
//   underrun     : one-cycle pulse when a period starts with the FIFO empty
//   level        : FIFO occupancy for the MMIO status word
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    pwm_dac_if.slave               smp,
    output logic                   pwm_out,
    output logic                   period_start,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] head;
    logic             load;
    logic             pop;
    logic             push;
    logic             underrun_next;
    logic             full;
    logic             empty;

    // Ready comes from registered FIFO state only; a slot freed by a pop
    // this cycle is offered to the source on the following cycle.
    assign smp.sample_ready = !full;
    assign push             = smp.sample_valid && !full;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (smp.sample_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Idle parks the counter at its last value so the first enabled edge
    // wraps to zero and is therefore a load event.
    always_comb begin
        cnt_next      = '1;
        duty_next     = duty;
        load          = 1'b0;
        pop           = 1'b0;
        underrun_next = 1'b0;
        if (enable) begin
            cnt_next = cnt + 1'b1;
            load     = (cnt == '1);
            if (load) begin
                if (!empty) begin
                    duty_next = head;
                    pop       = 1'b1;
                end else begin
                    underrun_next = 1'b1;
                end
            end
        end
    end

    // pwm_out compares next-state values so the output lines up with cnt:
    // high for the first duty cycles of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '1;
            duty         <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            duty         <= duty_next;
            pwm_out      <= enable && (cnt_next < duty_next);
            period_start <= load;
            underrun     <= underrun_next;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac
// Self-checking bench for pwm_dac at WIDTH = 4 (period 16), DEPTH = 4.
// A fixed vector table covers FIFO backpressure and enable handling; hand
// sequences and a randomized run are checked against a period/queue model.
module tb_pwm_dac;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1 << WIDTH;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;
    logic [2:0] level;

    pwm_dac_if #(.WIDTH(WIDTH)) smp_if ();

    pwm_dac #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .smp          (smp_if),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVectors    = 0;
    int nMiscompares = 0;
    int cycle       = 0;

    // Reference model: position within the current period, the duty being
    // played, and the queue of pending samples.
    int pos;
    int duty;
    int q[$];
    bit mPwm;
    bit mPs;
    bit mUnd;

    typedef struct {
        bit         en;
        bit         valid;
        logic [3:0] data;
        logic [6:0] exp;   // {pwm, period_start, underrun, level[2:0], ready}
    } vec_t;

    vec_t tbl[11];

    function automatic logic [6:0] actualBundle();
        return {pwm_out, period_start, underrun, level, smp_if.sample_ready};
    endfunction

    function automatic logic [6:0] modelBundle();
        return {mPwm, mPs, mUnd, 3'(q.size()), (q.size() < DEPTH)};
    endfunction

    task automatic compareBundle(input string name, input logic [6:0] act, input logic [6:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s cycle %0d: pwm/ps/und/level/rdy got %b required %b", name, cycle, act, exp);
        end
    endtask

    task automatic modelReset();
        pos  = PERIOD - 1;
        duty = 0;
        q.delete();
        mPwm = 1'b0;
        mPs  = 1'b0;
        mUnd = 1'b0;
    endtask

    // One clock of the model, using the inputs held across this edge.
    task automatic modelStep(input bit en, input bit valid, input int data);
        bit rdy;
        rdy = (q.size() < DEPTH);
        if (en) begin
            pos  = (pos + 1) % PERIOD;
            mPs  = (pos == 0);
            mUnd = 1'b0;
            if (pos == 0) begin
                if (q.size() > 0) duty = q.pop_front();
                else              mUnd = 1'b1;
            end
            mPwm = (pos < duty);
        end else begin
            pos  = PERIOD - 1;
            mPwm = 1'b0;
            mPs  = 1'b0;
            mUnd = 1'b0;
        end
        if (valid && rdy) q.push_back(data);
    endtask

    task automatic applyStimulus(input bit en, input bit valid, input logic [3:0] data);
        enable              = en;
        smp_if.sample_valid = valid;
        smp_if.sample_data  = data;
        @(posedge clk);
        cycle++;
        modelStep(en, valid, int'(data));
        #1;
    endtask

    task automatic checkOutput(input string name);
        compareBundle(name, actualBundle(), modelBundle());
    endtask

    // Assert reset mid-cycle, check outputs drop without a clock edge,
    // then release on a falling edge and check the idle state.
    task automatic doReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compareBundle("async_reset", {pwm_out, period_start, underrun, level, 1'b0}, 7'b0);
        enable              = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_data  = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0);
        compareBundle("post_reset", actualBundle(), 7'b0000001);
    endtask

    task automatic runIdle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0);
            checkOutput(name);
        end
    endtask

    initial begin
        rst_n               = 1'b1;
        enable              = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_data  = '0;
        modelReset();

        // Backpressure and enable handling, expectations written out by hand
        tbl[0]  = '{1'b0, 1'b1, 4'd3,  7'b0000011};
        tbl[1]  = '{1'b0, 1'b1, 4'd5,  7'b0000101};
        tbl[2]  = '{1'b0, 1'b1, 4'd7,  7'b0000111};
        tbl[3]  = '{1'b0, 1'b1, 4'd9,  7'b0001000};
        tbl[4]  = '{1'b0, 1'b1, 4'd11, 7'b0001000};
        tbl[5]  = '{1'b1, 1'b1, 4'd11, 7'b1100111};
        tbl[6]  = '{1'b1, 1'b1, 4'd11, 7'b1001000};
        tbl[7]  = '{1'b1, 1'b0, 4'd0,  7'b1001000};
        tbl[8]  = '{1'b1, 1'b0, 4'd0,  7'b0001000};
        tbl[9]  = '{1'b0, 1'b0, 4'd0,  7'b0001000};
        tbl[10] = '{1'b1, 1'b0, 4'd0,  7'b1100111};

        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].en, tbl[i].valid, tbl[i].data);
            compareBundle($sformatf("table[%0d]", i), actualBundle(), tbl[i].exp);
        end

        // pwm_out is high here; reset must drop it and empty the FIFO at once
        doReset();

        // Single sample 5 loaded on the first enabled edge
        applyStimulus(1'b0, 1'b1, 4'd5);
        checkOutput("push5_idle");
        runIdle(2 * PERIOD + 2, "duty5");

        // Duty extremes: 0 then 15
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd0);
        checkOutput("push0");
        applyStimulus(1'b0, 1'b1, 4'd15);
        checkOutput("push15");
        runIdle(2 * PERIOD + 2, "duty0_15");

        // One sample, three periods: later periods underrun and repeat it
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd8);
        checkOutput("push8");
        runIdle(3 * PERIOD + 2, "underrun8");

        // Push on the very load edge with an empty FIFO
        doReset();
        applyStimulus(1'b1, 1'b1, 4'd9);
        checkOutput("push_at_load");
        runIdle(2 * PERIOD + 2, "after_push_at_load");

        // Randomized traffic with enable drops
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 24) != 0,
                          $urandom_range(0, 13) == 0,
                          4'($urandom_range(0, 15)));
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Consumer end of the audio sample path: accepts unsigned WIDTH-bit wave samples (e.g. sine generator output) over a valid/ready interface.
- Buffers samples in a small FIFO and renders them as a 1-bit PWM waveform for the board audio output.
- One sample per PWM period of 2^WIDTH clocks.
- Reports underruns and FIFO fill level to the CPU-side MMIO.

Parameters:
- WIDTH, 12: sample width; PWM period = 2^WIDTH clocks.
- DEPTH, 4: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run PWM; when low, output is idle and the FIFO still accepts samples.
- sample_data  in  WIDTH  unsigned duty code.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  FIFO can accept; equals !full, registered-state only.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  high during the first cycle of each period.
- underrun  out  1  one-cycle pulse when a period starts with the FIFO empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - cnt = 2^WIDTH-1, duty = 0.
  - pwm_out = 0, period_start = 0, underrun = 0.
  - FIFO empty, level = 0, sample_ready = 1.
- Push: occurs on an edge where sample_valid && sample_ready. There is no bypass; a pushed sample is readable from the next cycle.
- sample_ready does not depend combinationally on a same-cycle pop. A slot freed by a pop is visible the cycle after.
- Counter:
  - When enable = 0: cnt is forced to 2^WIDTH-1; pwm_out = 0; period_start = 0; duty is held.
  - When enable = 1: cnt increments each clock. The wrap edge (cnt = 2^WIDTH-1 -> 0) is the load event.
  - The first enabled edge after idle is therefore a load event.
- Load event:
  - FIFO non-empty: duty <= head, pop.
  - FIFO empty: duty is held and underrun pulses for the one cycle where cnt = 0.
- pwm_out is registered as (cnt_next < duty_next), so it is aligned with cnt:
  - High for exactly duty cycles at the start of each period, then low for the remainder.
  - duty 0 gives a constant low. duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
- period_start is registered; high exactly when cnt = 0 and enable = 1.
- Latency: a sample pushed at edge t, with the FIFO otherwise empty, drives pwm_out from the first load event strictly after t.
- Simultaneous push and load:
  - FIFO empty: the load sees empty, so underrun fires. The push is stored and consumed at the next load.
  - FIFO full: no push (ready = 0); the pop proceeds.
  - Otherwise: both happen and level is unchanged.
- enable falling mid-period: the period is abandoned immediately (next edge). The FIFO is untouched and duty is held.
- Reset mid-operation: all state returns to reset values immediately, FIFO contents are discarded, pwm_out drops to 0 without waiting for a clock.
- Arithmetic: cnt and duty are WIDTH bits, compared unsigned; cnt wraps modulo 2^WIDTH. FIFO pointers are $clog2(DEPTH)+1 bits, with the extra MSB distinguishing full from empty.

Decomposition:
- Shared package/header: default WIDTH and DEPTH, and the MMIO status bit positions (underrun, level).
- Sub-module sample_fifo: synchronous FIFO, parameterised (WIDTH, DEPTH).
  - Ports: clk, rst_n, push, din, pop, dout, full, empty, level.
  - Registered state only; reads are first-word-fall-through (head visible on dout when !empty).
- pwm_dac holds the counter, duty register, load control and output registers.

Test Plan (WIDTH = 4 for speed, period 16, DEPTH = 4):
1. Assert rst_n low mid-clock -> pwm_out, period_start, underrun = 0 and level = 0 immediately; sample_ready = 1 after release.
2. Push 5 with enable = 0, then enable = 1 -> period_start every 16 clocks; pwm_out high 5 cycles, low 11; level 1 -> 0 at the first load.
3. Push 0 then 15 -> first period pwm_out constantly low; second period high 15 cycles, low 1.
4. Push only 8, run 3 periods -> underrun pulses at the 2nd and 3rd period_start; pwm_out stays 8 high / 8 low.
5. enable = 0, push 5 samples back-to-back -> sample_ready drops after the 4th, level = 4, 5th sample held by source. Set enable = 1 -> ready rises the cycle after the first pop and the 5th is accepted.
6. Push at exactly the cycle of the first load with the FIFO empty -> underrun = 1 that period; the sample appears as duty in the following period.
